// File: rtl/clock_buffer.sv
`default_nettype none
// ============================================================================
// Module   : clock_buffer
// Brief    : Zero-delay root clock buffer with glitch-free gating, a
//            synchronised gate request and a delivered-pulse counter.
// Revision : 1.0
// ============================================================================
module clock_buffer #(
  parameter int SYNC_STAGES     = 2,
  parameter int RESET_GATE_OPEN = 1,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 clk_en,
  output logic                 clk_out,
  output logic                 gate_on,
  output logic [CNT_WIDTH-1:0] pulse_cnt
);

  localparam logic c_reset_gate = (RESET_GATE_OPEN != 0);

  // Power-up values let the clock pass without a reset when the gate defaults open.
  logic [SYNC_STAGES-1:0] r_sync   = {SYNC_STAGES{c_reset_gate}};
  logic                   r_gate_q = c_reset_gate;
  logic [CNT_WIDTH-1:0]   r_cnt    = '0;
  logic                   w_en_s;

  assign w_en_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{c_reset_gate}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], clk_en};
    end
  end

  // Updating only while clk_in is low means an AND gate can never chop a high phase.
  always_ff @(negedge clk_in) begin
    if (rst) begin
      r_gate_q <= c_reset_gate;
    end else begin
      r_gate_q <= w_en_s;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_gate_q) begin
      r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign clk_out   = clk_in & r_gate_q;
  assign gate_on   = r_gate_q;
  assign pulse_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clock_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_buffer
// Brief    : Self-checking bench for clock_buffer (three parameterisations).
// Revision : 1.0
// ============================================================================
module tb_clock_buffer;

  logic        clk_in = 1'b0;
  logic        rst0 = 1'b0, en0 = 1'b1;
  logic        rst1 = 1'b0, en1 = 1'b1;
  logic        clk_out0, gate_on0, clk_out1, gate_on1, clk_out2, gate_on2;
  logic [15:0] cnt0, cnt2;
  logic [3:0]  cnt1;

  int n_pass  = 0;
  int n_total = 0;

  initial forever #5 clk_in = ~clk_in;

  clock_buffer #(.SYNC_STAGES(2), .RESET_GATE_OPEN(1), .CNT_WIDTH(16)) u_dut0 (
    .clk_in(clk_in), .rst(rst0), .clk_en(en0),
    .clk_out(clk_out0), .gate_on(gate_on0), .pulse_cnt(cnt0)
  );

  clock_buffer #(.SYNC_STAGES(2), .RESET_GATE_OPEN(0), .CNT_WIDTH(4)) u_dut1 (
    .clk_in(clk_in), .rst(rst1), .clk_en(en1),
    .clk_out(clk_out1), .gate_on(gate_on1), .pulse_cnt(cnt1)
  );

  clock_buffer #(.SYNC_STAGES(3), .RESET_GATE_OPEN(1), .CNT_WIDTH(16)) u_dut2 (
    .clk_in(clk_in), .rst(rst0), .clk_en(en0),
    .clk_out(clk_out2), .gate_on(gate_on2), .pulse_cnt(cnt2)
  );

  // Edge timestamps and high-phase width monitors
  time last_in_rise = 0, last_out_rise = 0, rise1 = 0;
  bit  seen0 = 1'b0, seen1 = 1'b0;

  always @(posedge clk_in)  last_in_rise = $time;
  always @(posedge clk_out0) begin last_out_rise = $time; seen0 = 1'b1; end
  always @(posedge clk_out1) begin rise1 = $time; seen1 = 1'b1; end

  always @(negedge clk_out0) if (seen0) begin
    n_total++;
    if (($time - last_out_rise) !== 5)
      $display("FAIL width0 t=%0t high=%0t required=5", $time, $time - last_out_rise);
    else n_pass++;
  end

  always @(negedge clk_out1) if (seen1) begin
    n_total++;
    if (($time - rise1) !== 5)
      $display("FAIL width1 t=%0t high=%0t required=5", $time, $time - rise1);
    else n_pass++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic test_phase;
    time t1, t2, t4, t5;
    repeat (2) @(posedge clk_in);
    #1; t1 = last_in_rise; t4 = last_out_rise;
    @(posedge clk_in);
    #1; t2 = last_in_rise; t5 = last_out_rise;
    n_total++;
    if (((t5 - t4) - (t2 - t1)) !== 0)
      $display("FAIL phase_period got=%0t required=0", (t5 - t4) - (t2 - t1));
    else n_pass++;
    n_total++;
    if ((t4 - t1) !== 0) $display("FAIL phase_offset got=%0t required=0", t4 - t1);
    else n_pass++;
    #1;
  endtask

  task automatic test_reset;
    rst0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      n_total++;
      if (cnt0 !== 16'd0 || gate_on0 !== 1'b1 || clk_out0 !== 1'b1)
        $display("FAIL reset_hold cyc=%0d got cnt=%0d gate=%0b out=%0b required cnt=0 gate=1 out=1",
                 i, cnt0, gate_on0, clk_out0);
      else n_pass++;
      #1;
    end
    rst0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in); #1;
      n_total++;
      if (cnt0 !== 16'(i + 1) || gate_on0 !== 1'b1 || clk_out0 !== 1'b1)
        $display("FAIL run20 cyc=%0d got cnt=%0d gate=%0b out=%0b required cnt=%0d gate=1 out=1",
                 i, cnt0, gate_on0, clk_out0, i + 1);
      else n_pass++;
      #1;
    end
  endtask

  task automatic test_gate_toggle;
    logic exp_out[8]  = '{1, 1, 0, 0, 0, 0, 1, 1};
    int   exp_cnt[8]  = '{21, 22, 22, 22, 22, 22, 23, 24};
    logic exp_gate[8] = '{1, 1, 0, 0, 0, 0, 1, 1};
    en0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) en0 = 1'b1;
      @(posedge clk_in); #1;
      n_total++;
      if (clk_out0 !== exp_out[i] || cnt0 !== 16'(exp_cnt[i]) || gate_on0 !== exp_gate[i])
        $display("FAIL gate_toggle cyc=%0d got out=%0b cnt=%0d gate=%0b required out=%0b cnt=%0d gate=%0b",
                 i, clk_out0, cnt0, gate_on0, exp_out[i], exp_cnt[i], exp_gate[i]);
      else n_pass++;
      if (i == 1 || i == 5) begin
        #5;
        n_total++;
        if (gate_on0 !== (i == 5))
          $display("FAIL gate_negedge cyc=%0d got=%0b required=%0b", i, gate_on0, i == 5);
        else n_pass++;
      end else begin
        #1;
      end
    end
  endtask

  task automatic test_closed_reset;
    rst1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      n_total++;
      if (clk_out1 !== 1'b0 || cnt1 !== 4'd0 || gate_on1 !== 1'b0)
        $display("FAIL closed_reset cyc=%0d got out=%0b cnt=%0d gate=%0b required 0 0 0",
                 i, clk_out1, cnt1, gate_on1);
      else n_pass++;
      #1;
    end
    rst1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_in); #1;
      n_total++;
      if (clk_out1 !== 1'b0) $display("FAIL closed_latency cyc=%0d got=%0b required=0", i, clk_out1);
      else n_pass++;
      #1;
    end
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk_in); #1;
      n_total++;
      if (clk_out1 !== 1'b1 || cnt1 !== 4'(i))
        $display("FAIL wrap pulse=%0d got out=%0b cnt=%0d required out=1 cnt=%0d",
                 i, clk_out1, cnt1, i % 16);
      else n_pass++;
      #1;
    end
  endtask

  // Model: the clock edge at posedge m is delivered iff clk_en sampled at posedge m-S was 1.
  task automatic test_random;
    bit hist[$];
    bit e, exp0, exp2;
    int c0 = 0, c2 = 0;
    rst0 = 1'b1;
    repeat (2) begin @(posedge clk_in); #2; end
    rst0 = 1'b0;
    hist = '{1, 1, 1, 1};
    for (int n = 0; n < 60; n++) begin
      e = 1'($urandom_range(0, 1));
      en0 = e;
      hist.push_back(e);
      @(posedge clk_in); #1;
      exp0 = hist[hist.size() - 3];
      exp2 = hist[hist.size() - 4];
      c0 += int'(exp0);
      c2 += int'(exp2);
      n_total++;
      if (clk_out0 !== exp0 || gate_on0 !== exp0)
        $display("FAIL rand_gate_s2 n=%0d got out=%0b gate=%0b required=%0b", n, clk_out0, gate_on0, exp0);
      else n_pass++;
      n_total++;
      if (cnt0 !== 16'(c0)) $display("FAIL rand_cnt_s2 n=%0d got=%0d required=%0d", n, cnt0, c0);
      else n_pass++;
      n_total++;
      if (clk_out2 !== exp2 || gate_on2 !== exp2)
        $display("FAIL rand_gate_s3 n=%0d got out=%0b gate=%0b required=%0b", n, clk_out2, gate_on2, exp2);
      else n_pass++;
      n_total++;
      if (cnt2 !== 16'(c2)) $display("FAIL rand_cnt_s3 n=%0d got=%0d required=%0d", n, cnt2, c2);
      else n_pass++;
      #1;
    end
  endtask

  initial begin
    test_phase();
    test_reset();
    test_gate_toggle();
    test_closed_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
